// File: rtl/led_mode_sequencer.sv
// Button-driven LED mode controller: synchronise, debounce and arbitrate four active-low buttons.
// Optional macro LED_SEQ_PINGPONG_EN adds the PINGPONG bounce mode (button[3] pressed while in SHIFT).
module led_mode_sequencer #(
    parameter int TICK_DIV     = 13_500_000,
    parameter int DEBOUNCE_CYC = 270_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] button,
    output logic [3:0] led,
    output logic [2:0] mode,
    output logic       tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYC - 1);

    localparam logic [2:0] MODE_OFF      = 3'd0;
    localparam logic [2:0] MODE_ON       = 3'd1;
    localparam logic [2:0] MODE_BLINK    = 3'd2;
    localparam logic [2:0] MODE_SHIFT    = 3'd3;
`ifdef LED_SEQ_PINGPONG_EN
    localparam logic [2:0] MODE_PINGPONG = 3'd4;
`endif

    localparam logic [3:0] LED_ALL_OFF = 4'b1111;
    localparam logic [3:0] LED_ALL_ON  = 4'b0000;
    localparam logic [3:0] LED_BIT0    = 4'b1110;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    db_q, db_d;
    logic [3:0]    db_dly_q, db_dly_d;
    logic [3:0]    evt_q, evt_d;
    logic [CW-1:0] db_cnt_q [4];
    logic [CW-1:0] db_cnt_d [4];
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    mode_q, mode_d;
    logic [3:0]    led_q, led_d;
`ifdef LED_SEQ_PINGPONG_EN
    logic          dir_q, dir_d;   // 1 = lit LED moving toward bit3
`endif

    logic          evt_any;
    logic [2:0]    evt_mode;

    assign tick = (presc_q == PRESC_MAX);
    assign led  = led_q;
    assign mode = mode_q;

    // A debounced level only changes after the synced input has differed for DEBOUNCE_CYC cycles.
    always_comb begin
        sync1_d  = button;
        sync2_d  = sync1_q;
        db_dly_d = db_q;
        evt_d    = db_dly_q & ~db_q;
        db_d     = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        evt_any  = |evt_q;
        evt_mode = MODE_OFF;
        if (evt_q[1]) begin
            evt_mode = MODE_OFF;
        end else if (evt_q[0]) begin
            evt_mode = MODE_ON;
        end else if (evt_q[2]) begin
            evt_mode = MODE_BLINK;
        end else if (evt_q[3]) begin
`ifdef LED_SEQ_PINGPONG_EN
            evt_mode = (mode_q == MODE_SHIFT) ? MODE_PINGPONG : MODE_SHIFT;
`else
            evt_mode = MODE_SHIFT;
`endif
        end
    end

    // An accepted event always wins over a coincident tick and restarts the prescaler.
    always_comb begin
        mode_d  = mode_q;
        led_d   = led_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
`ifdef LED_SEQ_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (evt_any) begin
            presc_d = '0;
            mode_d  = evt_mode;
            case (evt_mode)
                MODE_OFF:   led_d = LED_ALL_OFF;
                MODE_ON:    led_d = LED_ALL_ON;
                MODE_BLINK: led_d = LED_ALL_ON;
                default: begin
                    led_d = LED_BIT0;
`ifdef LED_SEQ_PINGPONG_EN
                    dir_d = 1'b1;
`endif
                end
            endcase
        end else begin
            case (mode_q)
                MODE_OFF: led_d = LED_ALL_OFF;
                MODE_ON:  led_d = LED_ALL_ON;
                MODE_BLINK: begin
                    if (tick) led_d = ~led_q;
                end
                MODE_SHIFT: begin
                    if (tick) led_d = {led_q[0], led_q[3:1]};
                end
`ifdef LED_SEQ_PINGPONG_EN
                MODE_PINGPONG: begin
                    if (tick) begin
                        if (dir_q) begin
                            if (led_q == 4'b0111) begin
                                dir_d = 1'b0;
                                led_d = {led_q[0], led_q[3:1]};
                            end else begin
                                led_d = {led_q[2:0], led_q[3]};
                            end
                        end else begin
                            if (led_q == LED_BIT0) begin
                                dir_d = 1'b1;
                                led_d = {led_q[2:0], led_q[3]};
                            end else begin
                                led_d = {led_q[0], led_q[3:1]};
                            end
                        end
                    end
                end
`endif
                default: begin
                    mode_d = MODE_OFF;
                    led_d  = LED_ALL_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            db_q     <= 4'hF;
            db_dly_q <= 4'hF;
            evt_q    <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            presc_q  <= '0;
            mode_q   <= MODE_OFF;
            led_q    <= LED_ALL_OFF;
`ifdef LED_SEQ_PINGPONG_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            evt_q    <= evt_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
`ifdef LED_SEQ_PINGPONG_EN
            dir_q    <= dir_d;
`endif
        end
    end
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: directed and random button activity checked every cycle
// against a press-event / step-count reference model.
module tb_led_mode_sequencer;
  localparam int TICK_DIV     = 8;
  localparam int DEBOUNCE_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] button;
  logic [3:0] led;
  logic [2:0] mode;
  logic       tick;

  int total = 0;
  int bad   = 0;
  int first;

  led_mode_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .led    (led),
    .mode   (mode),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus cycles elapsed since the last accepted event (or reset).
  int         m_mode;
  int         m_cnt;
  logic [3:0] m_deb;
  int         m_run [4];
  logic [3:0] raw_hist[$];
  logic [3:0] ev_pipe[$];

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_deb  = 4'hF;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    raw_hist = '{4'hF, 4'hF};
    ev_pipe  = '{4'h0, 4'h0};
  endtask

  // Debouncer sees the level sampled two edges earlier; a press acts two edges after it is accepted.
  task automatic model_edge(input logic [3:0] b);
    logic [3:0] seen;
    logic [3:0] fell;
    logic [3:0] ev;
    seen = raw_hist.pop_front();
    raw_hist.push_back(b);
    fell = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (seen[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEBOUNCE_CYC) begin
          m_deb[i] = seen[i];
          m_run[i] = 0;
          if (!seen[i]) fell[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    ev = ev_pipe.pop_front();
    ev_pipe.push_back(fell);
    if (ev != 4'h0) begin
      m_cnt = 0;
      if (ev[1]) m_mode = 0;
      else if (ev[0]) m_mode = 1;
      else if (ev[2]) m_mode = 2;
      else begin
`ifdef LED_SEQ_PINGPONG_EN
        m_mode = (m_mode == 3) ? 4 : 3;
`else
        m_mode = 3;
`endif
      end
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [3:0] exp_led(input int md, input int cnt);
    int k;
    int pos;
    k = cnt / TICK_DIV;
    pos = 0;
    exp_led = 4'b1111;
    case (md)
      0: exp_led = 4'b1111;
      1: exp_led = 4'b0000;
      2: exp_led = (k % 2 == 1) ? 4'b1111 : 4'b0000;
      3: begin
        pos = (4 - (k % 4)) % 4;
        exp_led = ~(4'b0001 << pos);
      end
      4: begin
        case (k % 6)
          0: pos = 0;
          1: pos = 1;
          2: pos = 2;
          3: pos = 3;
          4: pos = 2;
          default: pos = 1;
        endcase
        exp_led = ~(4'b0001 << pos);
      end
      default: exp_led = 4'b1111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(button);
    @(negedge clk);
    check("mode", 32'(mode), 32'(m_mode));
    check("led", 32'(led), 32'(exp_led(m_mode, m_cnt)));
    check("tick", 32'(tick), 32'(m_cnt % TICK_DIV == TICK_DIV - 1));
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int settle);
    button = ~mask;
    repeat (hold) step();
    button = 4'hF;
    repeat (settle) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    button = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'hF);
    check("reset_mode", 32'(mode), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    rst = 1'b1;
    repeat (5) step();

    // Short glitch must be filtered out.
    press(4'b0001, 3, 12);
    check("glitch_mode", 32'(mode), 32'h0);

    // Press-to-mode latency, then a held button gives no repeat.
    button = 4'hE;
    first  = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (first == 0 && mode == 3'd1) first = c;
    end
    check("latency", 32'(first), 32'd8);
    repeat (20) step();
    button = 4'hF;
    repeat (10) step();

    press(4'b0100, 6, 30);
    press(4'b1000, 6, 20);
    press(4'b1000, 6, 30);

    // Simultaneous presses.
    press(4'b0001, 6, 10);
    press(4'b0110, 6, 10);
    check("arb_off_mode", 32'(mode), 32'h0);
    check("arb_off_led", 32'(led), 32'hF);
    press(4'b1001, 6, 10);
    check("arb_on_mode", 32'(mode), 32'h1);

    // button[3] while in SHIFT.
    press(4'b1000, 6, 4);
    press(4'b1000, 6, 4);
`ifdef LED_SEQ_PINGPONG_EN
    check("pp_mode", 32'(mode), 32'h4);
`else
    check("pp_mode", 32'(mode), 32'h3);
`endif
    check("pp_led", 32'(led), 32'hE);
    repeat (60) step();

    for (int r = 0; r < 40; r++) begin
      button = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 10)) step();
    end
    button = 4'hF;
    repeat (12) step();

    // Asynchronous reset in the middle of a SHIFT pattern.
    press(4'b0010, 6, 4);
    press(4'b1000, 6, 13);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'hF);
    check("async_rst_mode", 32'(mode), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Button-driven controller that sequences the 4-LED output datapath through static and animated display modes. Debounces four active-low push buttons, arbitrates simultaneous presses, owns the pattern-rate prescaler and drives the active-low LED bus. It sits between the board buttons and LED pins, replacing ad-hoc per-button enable flags with one mode state machine.

## Interface

- `TICK_DIV`, 13_500_000, pattern step period in clk cycles (≈0.5 s at 27 MHz); ≥2
- `DEBOUNCE_CYC`, 270_000, cycles a button must hold a new level before it is accepted; ≥2
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `button` in 4: raw active-low buttons; [0]=ON, [1]=OFF, [2]=BLINK, [3]=SHIFT
- `led` out 4: active-low LED drive (0 = lit)
- `mode` out 3: current mode code
- `tick` out 1: one-cycle pattern step strobe

## Operation

- Reset values: `led`=4'b1111, `mode`=OFF (3'd0), `tick`=0, debounced states=1, counters=0, direction=up.
- Input path per button: 2-flop synchronizer → debouncer. Counter counts cycles where synced ≠ debounced; clears when equal; when it reaches DEBOUNCE_CYC-1 with inputs still differing, debounced level updates and counter clears.
- Press event: registered one-cycle pulse on debounced 1→0. Releases generate no event.
- Arbitration on same-cycle events: button[1] > [0] > [2] > [3]; lower-priority events that cycle are dropped.
- Modes: OFF=0 (led 1111), ON=1 (led 0000), BLINK=2, SHIFT=3, PINGPONG=4 (macro only).
- Transitions: any accepted event moves to its mode from any mode, including re-entry of the current mode (restarts pattern).
- Entry values: BLINK → 0000; SHIFT → 1110; PINGPONG → 1110, direction up.
- On tick: BLINK inverts all four bits; SHIFT rotates right, {led[0],led[3:1]} (1110→0111→1011→1101→1110); OFF/ON ignore tick.
- Mode code values 5–7 unreachable; if reached, fall to OFF.

## Timing

- Prescaler counts 0..TICK_DIV-1; `tick`=1 in the cycle count=TICK_DIV-1; free-running except cleared to 0 on every accepted event.
- First animated step after mode entry: exactly TICK_DIV cycles after the entry edge.
- Latency, stable raw press to `mode`/`led` change: 2 (sync) + DEBOUNCE_CYC (debounce) + 1 (event) + 1 (FSM) cycles.
- Event coinciding with tick: event wins; entry value loaded, no step applied.
- Glitch shorter than DEBOUNCE_CYC cycles: no event, no output change.
- Held button: single event; no repeat.
- `rst` asserted mid-pattern: all outputs return to reset values immediately (async), regardless of clk.

## Configuration

- `LED_SEQ_PINGPONG_EN` defined: button[3] event while in SHIFT enters PINGPONG (from any other mode it enters SHIFT). In PINGPONG the single lit LED moves bit0→1→2→3→2→1→0… one position per tick, reversing at bit3 and bit0 (1110,1101,1011,0111,1011,…); no position repeats at the ends.
- Undefined: PINGPONG state, direction register and logic absent; button[3] event in SHIFT re-enters SHIFT (led 1110, prescaler cleared).

## Test plan

Benches use TICK_DIV=8, DEBOUNCE_CYC=4.
- Reset: assert `rst`=0 mid-SHIFT without clk edge → `led`=1111, `mode`=0, `tick`=0 immediately.
- Debounce: button[0] low 3 cycles then high → no change; low 10 cycles → `mode`=1, `led`=0000 exactly 2+4+1+1 cycles after falling edge.
- BLINK: press button[2] → `led`=0000, then 1111 after 8 cycles, 0000 after 16; `tick` pulses every 8 cycles.
- SHIFT: press button[3] → 1110, then 0111, 1011, 1101, 1110 at 8-cycle steps; re-press mid-pattern → 1110 and step 8 cycles later.
- Arbitration: button[1] and button[2] debounced in same cycle from ON → `mode`=0, `led`=1111; [0]+[3] together → `mode`=1.
- With LED_SEQ_PINGPONG_EN: SHIFT then button[3] → `mode`=4, sequence 1110,1101,1011,0111,1011,1101,1110,1101; without macro → `mode`=3, `led`=1110.
